pu_or1k_dpram_fifo_ctrl: RTL and testbench

//  Synchronous FIFO controller that sequences one single-clock simple dual-port RAM
//   (1-cycle registered read, write-to-read bypass enabled) as FIFO storage.

---
 rtl/pu_or1k_fifo_pkg.sv | 11 +
 rtl/pu_or1k_dpram_fifo_ctrl_ram.sv | 49 ++++
 rtl/pu_or1k_dpram_fifo_ctrl.sv | 116 +++++++++++
 tb/tb_pu_or1k_dpram_fifo_ctrl.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/pu_or1k_fifo_pkg.sv
// Shared types for the OR1K dual-port-RAM FIFO controller.
// Holds the output-stage state encoding; parametric types stay local to the modules.
package pu_or1k_fifo_pkg;

  // Output stage: is a head entry currently presented on rd_data?
  typedef enum logic [0:0] {
    OUT_EMPTY = 1'b0,
    OUT_VALID = 1'b1
  } out_state_t;

endpackage

// File: rtl/pu_or1k_dpram_fifo_ctrl_ram.sv
// Single-clock simple dual-port RAM used as FIFO storage.
// One write port, one read port with a 1-cycle registered read. The read
// register holds its value while re=0. With ENABLE_BYPASS set, a same-cycle
// write to the slot being read is forwarded to the read register.
// Contents are not cleared at init; the controller never reads an unwritten slot.
module pu_or1k_dpram_fifo_ctrl_ram #(
  parameter int ADDR_WIDTH    = 4,
  parameter int DATA_WIDTH    = 32,
  parameter int ENABLE_BYPASS = 1
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  bypass_hit;

  generate
    if (ENABLE_BYPASS != 0) begin : g_bypass
      assign bypass_hit = we & (waddr == raddr);
    end else begin : g_no_bypass
      assign bypass_hit = 1'b0;
    end
  endgenerate

  // Storage write port.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Registered read port; holds the last read value while re is low.
  always_ff @(posedge clk) begin
    if (re) begin
      rdata <= bypass_hit ? wdata : mem[raddr];
    end else begin
      rdata <= rdata;
    end
  end

endmodule

// File: rtl/pu_or1k_dpram_fifo_ctrl.sv
// FIFO controller sequencing a simple dual-port RAM as storage.
// Ready/valid push port, first-word-fall-through pop port. The head entry
// lives in the RAM read register, so there is no separate output register.
// Optional build macro PU_OR1K_FIFO_LEVEL_EN exposes the occupancy on 'level'.
module pu_or1k_dpram_fifo_ctrl
  import pu_or1k_fifo_pkg::*;
#(
  parameter int DEPTH_WIDTH = 4,
  parameter int DATA_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [DATA_WIDTH-1:0] rd_data
`ifdef PU_OR1K_FIFO_LEVEL_EN
  ,
  output logic [DEPTH_WIDTH:0]  level
`endif
);

  localparam int DEPTH = 1 << DEPTH_WIDTH;
  localparam int CNT_W = DEPTH_WIDTH + 1;

  localparam logic [CNT_W-1:0]       DEPTH_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]       CNT_ONE   = CNT_W'(1);
  localparam logic [DEPTH_WIDTH-1:0] PTR_ONE   = DEPTH_WIDTH'(1);

  logic [DEPTH_WIDTH-1:0] wptr;
  logic [DEPTH_WIDTH-1:0] rptr;
  logic [CNT_W-1:0]       count;
  logic [CNT_W-1:0]       count_next;
  logic [CNT_W-1:0]       pending;
  out_state_t             out_state;
  logic                   push;
  logic                   pop;
  logic                   we;
  logic                   re;

  assign rd_valid = (out_state == OUT_VALID);
  assign push     = wr_valid & wr_ready;
  assign pop      = rd_valid & rd_ready;

  // Entries in RAM not yet fetched into the read register.
  assign pending  = count - {{DEPTH_WIDTH{1'b0}}, rd_valid};

  // Writes and reads are suppressed in a clearing cycle so nothing leaks past it.
  // A read is issued when something is fetchable (stored, or being written now
  // into an empty RAM via the bypass) and the output slot is free or being freed.
  assign we = push & ~flush & ~rst;
  assign re = ((pending != {CNT_W{1'b0}}) | push)
            & ((out_state == OUT_EMPTY) | pop)
            & ~flush & ~rst;

`ifdef PU_OR1K_FIFO_LEVEL_EN
  assign level = count;
`endif

  // Occupancy update: push-only grows, pop-only shrinks, both leaves it unchanged.
  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + CNT_ONE;
      2'b01:   count_next = count - CNT_ONE;
      default: count_next = count;
    endcase
  end

  // Pointers, occupancy, output-stage state and the registered push-ready flag.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wptr      <= {DEPTH_WIDTH{1'b0}};
      rptr      <= {DEPTH_WIDTH{1'b0}};
      count     <= {CNT_W{1'b0}};
      out_state <= OUT_EMPTY;
      wr_ready  <= 1'b1;
    end else begin
      if (we) begin
        wptr <= wptr + PTR_ONE;
      end else begin
        wptr <= wptr;
      end
      if (re) begin
        rptr <= rptr + PTR_ONE;
      end else begin
        rptr <= rptr;
      end
      count    <= count_next;
      wr_ready <= (count_next != DEPTH_CNT);
      case (out_state)
        OUT_EMPTY: out_state <= re ? OUT_VALID : OUT_EMPTY;
        OUT_VALID: out_state <= (pop && !re) ? OUT_EMPTY : OUT_VALID;
        default:   out_state <= OUT_EMPTY;
      endcase
    end
  end

  pu_or1k_dpram_fifo_ctrl_ram #(
    .ADDR_WIDTH    (DEPTH_WIDTH),
    .DATA_WIDTH    (DATA_WIDTH),
    .ENABLE_BYPASS (1)
  ) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (wptr),
    .wdata (wr_data),
    .re    (re),
    .raddr (rptr),
    .rdata (rd_data)
  );

endmodule

// File: tb/tb_pu_or1k_dpram_fifo_ctrl.sv
// Scoreboard bench for pu_or1k_dpram_fifo_ctrl (DEPTH_WIDTH=4, DATA_WIDTH=32).
// Stimulus drives directed vectors just after each rising edge; the monitor on
// the falling edge keeps the expected contents in a queue, checks the handshake
// flags against the queue occupancy and compares every pop against the queue head.
module tb_pu_or1k_dpram_fifo_ctrl;

  localparam int DW    = 4;
  localparam int W     = 32;
  localparam int DEPTH = 16;
  localparam int EXP_POPS = 118;

  logic          clk      = 1'b0;
  logic          rst      = 1'b1;
  logic          flush    = 1'b0;
  logic          wr_valid = 1'b0;
  logic          rd_ready = 1'b0;
  logic [W-1:0]  wr_data  = 32'h0;
  logic          wr_ready;
  logic          rd_valid;
  logic [W-1:0]  rd_data;
`ifdef PU_OR1K_FIFO_LEVEL_EN
  logic [DW:0]   level;
`endif

  int            total    = 0;
  int            bad      = 0;
  int            pops     = 0;
  logic [W-1:0]  q [$];
  bit            armed    = 1'b0;
  bit            done_req = 1'b0;
  bit            done_ack = 1'b0;

  pu_or1k_dpram_fifo_ctrl #(
    .DEPTH_WIDTH (DW),
    .DATA_WIDTH  (W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .wr_data  (wr_data),
    .rd_valid (rd_valid),
    .rd_ready (rd_ready),
    .rd_data  (rd_data)
`ifdef PU_OR1K_FIFO_LEVEL_EN
    ,
    .level    (level)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor / scoreboard.
  always @(negedge clk) begin
    logic [W-1:0] exp_data;
    bit           accept;
    if (armed) begin
      check("rd_valid", {63'd0, rd_valid}, {63'd0, (q.size() != 0)});
      check("wr_ready", {63'd0, wr_ready}, {63'd0, (q.size() < DEPTH)});
`ifdef PU_OR1K_FIFO_LEVEL_EN
      check("level", {59'd0, level}, 64'(q.size()));
`endif
    end
    if (rst || flush) begin
      q.delete();
    end else begin
      accept = wr_valid && (q.size() < DEPTH);
      if ((q.size() != 0) && rd_ready) begin
        exp_data = q.pop_front();
        pops++;
        if (armed) check("rd_data", {32'd0, rd_data}, {32'd0, exp_data});
      end
      if (accept) q.push_back(wr_data);
    end
    if (done_req && !done_ack) begin
      check("pop_count", 64'(pops), 64'(EXP_POPS));
      check("sb_empty", 64'(q.size()), 64'd0);
      done_ack = 1'b1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Initial reset, two edges.
    rst = 1'b1;
    step();
    armed = 1'b1;
    step();
    rst = 1'b0;

    // Reset mid-traffic with 5 entries held.
    wr_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wr_data = 32'd100 + 32'(i);
      step();
    end
    wr_valid = 1'b0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();

    // Fill to 16; the 17th push must be ignored.
    rd_ready = 1'b0;
    wr_valid = 1'b1;
    for (int i = 0; i < 17; i++) begin
      wr_data = 32'(i);
      step();
    end
    wr_valid = 1'b0;
    step();

    // Drain 0x0..0xF on consecutive cycles, then empty.
    rd_ready = 1'b1;
    repeat (17) step();
    rd_ready = 1'b0;

    // Bypass: push into empty, held one cycle, then popped.
    wr_valid = 1'b1;
    wr_data  = 32'hDEADBEEF;
    step();
    wr_valid = 1'b0;
    step();
    rd_ready = 1'b1;
    step();
    rd_ready = 1'b0;

    // Streaming: 100 cycles of simultaneous push and pop.
    wr_valid = 1'b1;
    rd_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      wr_data = 32'd1000 + 32'(i);
      step();
    end
    wr_valid = 1'b0;
    step();
    step();
    rd_ready = 1'b0;

    // Flush with 7 entries and a simultaneous push+pop.
    wr_valid = 1'b1;
    for (int i = 0; i < 7; i++) begin
      wr_data = 32'd200 + 32'(i);
      step();
    end
    flush    = 1'b1;
    rd_ready = 1'b1;
    wr_data  = 32'hAA;
    step();
    flush    = 1'b0;
    wr_valid = 1'b0;
    rd_ready = 1'b0;
    step();
    wr_valid = 1'b1;
    wr_data  = 32'h55;
    step();
    wr_valid = 1'b0;
    step();
    rd_ready = 1'b1;
    step();
    rd_ready = 1'b0;
    step();

    // Final bookkeeping checks in the monitor.
    done_req = 1'b1;
    for (int k = 0; k < 4 && !done_ack; k++) step();
    if (!done_ack) begin
      $display("FAIL final_check: got no ack expected ack");
      $fatal(1, "final check did not complete");
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
